// File: rtl/crop_seq_ctrl.sv
// Capture sequencer for the 28x28 crop/normalize/classify pipeline.
// Optional macro CROP_SEQ_CONT_EN: DONE loops back to CLEAR for continuous capture.
module crop_seq_ctrl #(
    parameter int N_SAMPLES = 784,
    parameter int CLR_CYC   = 2,
    parameter int TO_CYC    = 1048575
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic       iABORT,
    input  logic       iFVAL,
    input  logic       iSMP_RDY,
    input  logic       iNORM_DONE,
    input  logic       iNN_DONE,
    output logic       oBUF_RST,
    output logic       oCAP_EN,
    output logic       oNN_START,
    output logic       oBUSY,
    output logic       oFRAME_DONE,
    output logic       oERR,
    output logic [9:0] oSMP_CNT,
    output logic [2:0] oSTATE
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLEAR    = 3'd1;
    localparam logic [2:0] WAIT_SOF = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] NORM     = 3'd4;
    localparam logic [2:0] CLASSIFY = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam logic [9:0]  N_LAST   = 10'(N_SAMPLES);
    localparam logic [3:0]  CLR_LAST = 4'(CLR_CYC - 1);
    localparam logic [19:0] TO_LAST  = 20'(TO_CYC - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [3:0]  clr_cnt;
    logic [3:0]  clr_cnt_nxt;
    logic [19:0] wd_cnt;
    logic [19:0] wd_cnt_nxt;
    logic        fval_d;
    logic        fval_rise;
    logic        fval_fall;
    logic        timeout;
    logic [9:0]  smp_inc;
    logic [9:0]  smp_cnt_nxt;
    logic        buf_rst_nxt;
    logic        cap_en_nxt;
    logic        nn_start_nxt;
    logic        frame_done_nxt;
    logic        err_nxt;

    assign fval_rise = iFVAL & ~fval_d;
    assign fval_fall = ~iFVAL & fval_d;
    assign timeout   = (wd_cnt == TO_LAST);
    assign smp_inc   = oSMP_CNT + 10'd1;
    assign oSTATE    = state;

    // Next-state and next-output logic; every output is the registered copy of its *_nxt.
    always_comb begin
        state_nxt      = state;
        clr_cnt_nxt    = clr_cnt;
        smp_cnt_nxt    = oSMP_CNT;
        err_nxt        = oERR;
        buf_rst_nxt    = 1'b0;
        cap_en_nxt     = 1'b0;
        nn_start_nxt   = 1'b0;
        frame_done_nxt = 1'b0;

        if (iABORT && state != IDLE) begin
            state_nxt   = IDLE;
            buf_rst_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state_nxt   = CLEAR;
                        err_nxt     = 1'b0;
                        clr_cnt_nxt = 4'd0;
                        smp_cnt_nxt = 10'd0;
                        buf_rst_nxt = 1'b1;
                    end
                end
                CLEAR: begin
                    smp_cnt_nxt = 10'd0;
                    if (clr_cnt == CLR_LAST) begin
                        state_nxt = WAIT_SOF;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 4'd1;
                        buf_rst_nxt = 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (fval_rise) begin
                        state_nxt  = CAPTURE;
                        cap_en_nxt = 1'b1;
                    end
                end
                CAPTURE: begin
                    cap_en_nxt = 1'b1;
                    if (iSMP_RDY && oSMP_CNT != N_LAST) begin
                        smp_cnt_nxt = smp_inc;
                    end
                    // The final sample wins over a simultaneous frame-valid fall.
                    if (iSMP_RDY && smp_inc == N_LAST) begin
                        state_nxt  = NORM;
                        cap_en_nxt = 1'b0;
                    end else if (fval_fall) begin
                        state_nxt  = IDLE;
                        cap_en_nxt = 1'b0;
                        err_nxt    = 1'b1;
                    end
                end
                NORM: begin
                    if (iNORM_DONE) begin
                        state_nxt    = CLASSIFY;
                        nn_start_nxt = 1'b1;
                    end else if (timeout) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                CLASSIFY: begin
                    if (iNN_DONE) begin
                        state_nxt      = DONE;
                        frame_done_nxt = 1'b1;
                    end else if (timeout) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                DONE: begin
`ifdef CROP_SEQ_CONT_EN
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = 4'd0;
                    smp_cnt_nxt = 10'd0;
                    buf_rst_nxt = 1'b1;
`else
                    state_nxt = IDLE;
`endif
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (state_nxt == state && (state == NORM || state == CLASSIFY)) begin
            wd_cnt_nxt = wd_cnt + 20'd1;
        end else begin
            wd_cnt_nxt = 20'd0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            clr_cnt     <= 4'd0;
            wd_cnt      <= 20'd0;
            fval_d      <= 1'b0;
            oSMP_CNT    <= 10'd0;
            oERR        <= 1'b0;
            oBUF_RST    <= 1'b0;
            oCAP_EN     <= 1'b0;
            oNN_START   <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            wd_cnt      <= wd_cnt_nxt;
            fval_d      <= iFVAL;
            oSMP_CNT    <= smp_cnt_nxt;
            oERR        <= err_nxt;
            oBUF_RST    <= buf_rst_nxt;
            oCAP_EN     <= cap_en_nxt;
            oNN_START   <= nn_start_nxt;
            oFRAME_DONE <= frame_done_nxt;
            oBUSY       <= (state_nxt != IDLE);
        end
    end

endmodule
